// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the memory bus arbiter: default widths, FSM encoding, port indices.
package mem_bus_arbiter_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic PORT_CPU    = 1'b0;
    localparam logic PORT_LOADER = 1'b1;

    // A zero-wait configuration still needs a 1-bit counter.
    function automatic int cnt_width(input int wait_cycles);
        return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter_2.sv
// Two-way round-robin winner select; purely combinational, pointer lives in the parent.
module rr_arbiter_2
    import mem_bus_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    output logic grant,
    output logic any
);

    assign any = req0 | req1;

    always_comb begin
        grant = PORT_CPU;
        if (req0 && req1) begin
            grant = ptr;
        end else if (req1) begin
            grant = PORT_LOADER;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin sharing of one memory between CPU (port 0) and loader (port 1),
// with a programmable number of held strobe cycles and a one-cycle ack per access.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int              CNT_W    = cnt_width(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

    state_t             state;
    logic               ptr;
    logic               we_lat;
    logic [CNT_W-1:0]   cnt;
    logic               win;
    logic               any_req;
    logic               g_we;
    logic [ADDR_W-1:0]  g_addr;
    logic [DATA_W-1:0]  g_wdata;

    rr_arbiter_2 u_rr (
        .req0  (req0),
        .req1  (req1),
        .ptr   (ptr),
        .grant (win),
        .any   (any_req)
    );

    assign g_we    = win ? we1    : we0;
    assign g_addr  = win ? addr1  : addr0;
    assign g_wdata = win ? wdata1 : wdata0;

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= PORT_CPU;
            we_lat    <= 1'b0;
            cnt       <= '0;
            owner     <= PORT_CPU;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata     <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        owner     <= win;
                        we_lat    <= g_we;
                        mem_addr  <= g_addr;
                        mem_wdata <= g_wdata;
                        mem_rd    <= ~g_we;
                        mem_wr    <= g_we;
                        cnt       <= '0;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // Address/data stay latched after the strobe drops so the bus never glitches.
                    if (cnt == CNT_LAST) begin
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        if (!we_lat) begin
                            rdata <= mem_rdata;
                        end
                        ack0  <= (owner == PORT_CPU);
                        ack1  <= (owner == PORT_LOADER);
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    ptr   <= ~owner;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: default-wait instance plus a zero-wait instance.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, we0, req1, we1;
    logic [12:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1, mem_rdata;
    logic        ack0, ack1, mem_rd, mem_wr, busy, owner;
    logic [7:0]  rdata, mem_wdata;
    logic [12:0] mem_addr;

    logic        z_req0, z_we0, z_req1, z_we1;
    logic [12:0] z_addr0, z_addr1;
    logic [7:0]  z_wdata0, z_wdata1, z_mem_rdata;
    logic        z_ack0, z_ack1, z_mem_rd, z_mem_wr, z_busy, z_owner;
    logic [7:0]  z_rdata, z_mem_wdata;
    logic [12:0] z_mem_addr;

    int checks = 0;
    int errors = 0;
    int both_strobe = 0;
    int both_ack = 0;
    int rd_n, wr_n, at, port, zat, zrd;
    logic [12:0] seen_addr;
    logic [7:0]  seen_wdata;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(13), .DATA_W(8), .WAIT_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
        .rdata(rdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    mem_bus_arbiter #(.ADDR_W(13), .DATA_W(8), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst_n(rst_n),
        .req0(z_req0), .we0(z_we0), .addr0(z_addr0), .wdata0(z_wdata0), .ack0(z_ack0),
        .req1(z_req1), .we1(z_we1), .addr1(z_addr1), .wdata1(z_wdata1), .ack1(z_ack1),
        .rdata(z_rdata), .mem_rd(z_mem_rd), .mem_wr(z_mem_wr), .mem_addr(z_mem_addr),
        .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata), .busy(z_busy), .owner(z_owner)
    );

    always @(negedge clk) begin
        if (mem_rd && mem_wr) both_strobe++;
        if (z_mem_rd && z_mem_wr) both_strobe++;
        if (ack0 && ack1) both_ack++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Ticks on falling edges until an ack shows up; at = ticks taken, port = which ack.
    task automatic wait_ack(input int budget, output int at_o, output int port_o);
        at_o = -1;
        port_o = -1;
        rd_n = 0;
        wr_n = 0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (mem_rd) begin rd_n++; seen_addr = mem_addr; end
            if (mem_wr) begin wr_n++; seen_addr = mem_addr; seen_wdata = mem_wdata; end
            if (ack0 || ack1) begin
                at_o = k;
                port_o = ack1 ? 1 : 0;
                break;
            end
        end
        if (at_o < 0) check("ack_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; mem_rdata = '0;
        z_req0 = 0; z_we0 = 0; z_addr0 = '0; z_wdata0 = '0;
        z_req1 = 0; z_we1 = 0; z_addr1 = '0; z_wdata1 = '0; z_mem_rdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        check("rst_ack0", ack0, 0);
        check("rst_ack1", ack1, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rdata", rdata, 0);
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);

        // Port 0 read
        addr0 = 13'h0100; we0 = 0; req0 = 1; mem_rdata = 8'hA5;
        wait_ack(10, at, port);
        check("rd_ack_lat", at, 3);
        check("rd_ack_port", port, 0);
        check("rd_strobe_cnt", rd_n, 2);
        check("rd_no_wr", wr_n, 0);
        check("rd_addr", seen_addr, 13'h0100);
        check("rd_rdata", rdata, 8'hA5);
        check("rd_owner", owner, 0);
        req0 = 0;
        @(negedge clk);
        check("rd_ack_one_cycle", ack0, 0);
        check("rd_idle_busy", busy, 0);

        // Port 1 write
        mem_rdata = 8'h77; req1 = 1; we1 = 1; addr1 = 13'h1FFF; wdata1 = 8'h3C;
        wait_ack(10, at, port);
        check("wr_ack_lat", at, 3);
        check("wr_ack_port", port, 1);
        check("wr_strobe_cnt", wr_n, 2);
        check("wr_no_rd", rd_n, 0);
        check("wr_addr", seen_addr, 13'h1FFF);
        check("wr_wdata", seen_wdata, 8'h3C);
        check("wr_rdata_held", rdata, 8'hA5);
        check("wr_owner", owner, 1);
        req1 = 0; we1 = 0;
        @(negedge clk);
        check("wr_ack_one_cycle", ack1, 0);
        check("wr_addr_hold", mem_addr, 13'h1FFF);

        // Port 1 arrives while port 0 is mid-access
        req0 = 1; we0 = 0; addr0 = 13'h0055; mem_rdata = 8'h5A;
        @(negedge clk);
        check("ovl_p0_strobe", mem_rd, 1);
        check("ovl_p0_owner", owner, 0);
        req1 = 1; we1 = 0; addr1 = 13'h0AAA;
        wait_ack(10, at, port);
        check("ovl_p0_ack_lat", at, 2);
        check("ovl_p0_port", port, 0);
        check("ovl_p0_rdata", rdata, 8'h5A);
        req0 = 0; mem_rdata = 8'hC3;
        wait_ack(10, at, port);
        check("ovl_p1_gap", at, 4);
        check("ovl_p1_port", port, 1);
        check("ovl_p1_addr", seen_addr, 13'h0AAA);
        check("ovl_p1_strobe_cnt", rd_n, 2);
        check("ovl_p1_rdata", rdata, 8'hC3);
        req1 = 0;
        @(negedge clk);

        // Leave pointer at port 1, then reset in the middle of a port 1 write
        req0 = 1; we0 = 1; addr0 = 13'h0123; wdata0 = 8'h11;
        wait_ack(10, at, port);
        check("pre_rst_port", port, 0);
        req0 = 0; we0 = 0;
        @(negedge clk);
        req1 = 1; we1 = 1; addr1 = 13'h0456; wdata1 = 8'h22;
        @(negedge clk);
        check("mid_wr_strobe", mem_wr, 1);
        check("mid_owner", owner, 1);
        #2;
        rst_n = 1'b0;
        req1 = 0; we1 = 0;
        #1;
        check("async_rst_wr", mem_wr, 0);
        check("async_rst_rd", mem_rd, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_owner", owner, 0);
        check("async_rst_ack1", ack1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_no_ack", ack1, 0);
        check("post_rst_idle", busy, 0);

        // Both requesting continuously: pointer must restart at port 0
        req0 = 1; we0 = 0; addr0 = 13'h0010;
        req1 = 1; we1 = 0; addr1 = 13'h0020; mem_rdata = 8'h99;
        for (int i = 0; i < 4; i++) begin
            wait_ack(10, at, port);
            check("rr_port", port, i % 2);
            check("rr_owner", owner, i % 2);
            check("rr_lat", at, (i == 0) ? 3 : 4);
            check("rr_addr", seen_addr, (i % 2) ? 13'h0020 : 13'h0010);
        end
        req0 = 0; req1 = 0;
        repeat (2) @(negedge clk);
        check("rr_idle", busy, 0);

        // Zero-wait instance read
        z_req0 = 1; z_we0 = 0; z_addr0 = 13'h0100; z_mem_rdata = 8'hA5;
        zat = -1; zrd = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (z_mem_rd) begin zrd++; check("w0_addr", z_mem_addr, 13'h0100); end
            if (z_ack0) begin zat = k; break; end
        end
        check("w0_ack_lat", zat, 2);
        check("w0_strobe_cnt", zrd, 1);
        check("w0_rdata", z_rdata, 8'hA5);
        z_req0 = 0;
        repeat (2) @(negedge clk);
        check("w0_idle", z_busy, 0);

        check("never_both_strobes", both_strobe, 0);
        check("never_both_acks", both_ack, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
